// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM memory port arbiter: FSM state encoding and counter sizing.
// Pure declarations; no latency or backpressure of its own.
package mem_port_arbiter_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    // Encoding is visible to the pipeline top for debug, so values are pinned.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        I_ACC = 2'd1,
        D_ACC = 2'd2
    } arb_state_t;

    function automatic int ctr_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and memory-side bundle of the arbiter; slave = arbiter, master = pipeline + memory.
// Wires only; req held until done, mem_ready is a one-cycle completion pulse.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_flush;
    logic [DATA_W-1:0] i_rdata;
    logic              i_done;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              stall;
    logic              err;

    modport slave (
        input  i_req, i_addr, i_flush, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output i_rdata, i_done, d_rdata, d_done, mem_addr, mem_wdata, mem_read, mem_write,
               stall, err
    );

    modport master (
        output i_req, i_addr, i_flush, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  i_rdata, i_done, d_rdata, d_done, mem_addr, mem_wdata, mem_read, mem_write,
               stall, err
    );

endinterface

// File: rtl/mem_timeout_ctr.sv
// Access watchdog: counts cycles while enabled, flags the TIMEOUT-th cycle; cleared while idle.
// expired is combinational from the count; no backpressure.
module mem_timeout_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int            CW       = ctr_width(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CNT_MAX)) begin
            count <= count + CW'(1);
        end
    end

    // count starts at 0 on the first strobe cycle, so LAST marks the TIMEOUT-th waiting cycle.
    assign expired = enable && (count >= CNT_LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IF fetches and MEM loads/stores, data first; strobe 1 cycle after grant.
// Completion (mem_ready or timeout) gives a done pulse the next cycle; requester stalls until then.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ARB_ADDR_W,
    parameter int DATA_W  = ARB_DATA_W,
    parameter int TIMEOUT = 255
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);

    arb_state_t        state_q, state_d;
    logic              grant_i, grant_d;
    logic              finish, timeout;
    logic              expired;
    logic              discard_q;
    logic              fetch_disc;
    logic              ctr_clear, ctr_en;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] rdata_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A request whose done pulse is high this cycle is already served and must not re-issue.
    always_comb begin
        state_d = state_q;
        grant_i = 1'b0;
        grant_d = 1'b0;
        finish  = 1'b0;
        timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.d_req && !bus.d_done) begin
                    grant_d = 1'b1;
                    state_d = D_ACC;
                end else if (bus.i_req && !bus.i_done && !bus.i_flush) begin
                    grant_i = 1'b1;
                    state_d = I_ACC;
                end
            end
            I_ACC, D_ACC: begin
                if (bus.mem_ready) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end else if (expired) begin
                    finish  = 1'b1;
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ctr_clear  = (state_q == IDLE);
    assign ctr_en     = (state_q != IDLE);
    assign fetch_disc = discard_q || bus.i_flush;
    assign grant_addr = grant_d ? bus.d_addr : bus.i_addr;
    assign rdata_nxt  = bus.mem_ready ? bus.mem_rdata : '0;

    mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout_ctr (
        .clk     (clk),
        .rst     (rst),
        .clear   (ctr_clear),
        .enable  (ctr_en),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.i_rdata   <= '0;
            bus.d_rdata   <= '0;
            bus.i_done    <= 1'b0;
            bus.d_done    <= 1'b0;
            bus.err       <= 1'b0;
            discard_q     <= 1'b0;
        end else begin
            bus.i_done <= 1'b0;
            bus.d_done <= 1'b0;

            if (grant_i || grant_d) begin
                bus.mem_addr  <= grant_addr;
                bus.mem_read  <= grant_i || !bus.d_we;
                bus.mem_write <= grant_d && bus.d_we;
            end
            if (grant_d) begin
                bus.mem_wdata <= bus.d_wdata;
            end

            // The memory cannot abort a read, so a flushed fetch runs out and its result is dropped.
            if (grant_i) begin
                discard_q <= 1'b0;
            end else if ((state_q == I_ACC) && bus.i_flush) begin
                discard_q <= 1'b1;
            end

            if (finish) begin
                bus.mem_read  <= 1'b0;
                bus.mem_write <= 1'b0;
                if ((state_q == I_ACC) && !fetch_disc) begin
                    bus.i_done  <= 1'b1;
                    bus.i_rdata <= rdata_nxt;
                end
                if (state_q == D_ACC) begin
                    bus.d_done <= 1'b1;
                    if (timeout || !bus.mem_write) begin
                        bus.d_rdata <= rdata_nxt;
                    end
                end
            end

            if (timeout) begin
                bus.err <= 1'b1;
            end
        end
    end

    assign bus.stall = (bus.d_req && !bus.d_done) || (bus.i_req && !bus.i_done && !bus.i_flush);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized transaction bench for mem_port_arbiter with an access-level model of rdata/err/done timing.
// The bench plays both the pipeline and a memory with per-access latency (or no response at all).
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int TIMEOUT = 4;

    logic clk;
    logic rst;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_irdata = '0;
    logic [31:0] m_drdata = '0;
    logic        m_err    = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_stall(input logic ddone, input logic idone);
        return (bus_if.d_req && !ddone) || (bus_if.i_req && !idone && !bus_if.i_flush);
    endfunction

    task automatic check_results(input string tag);
        check_eq({tag, "_i_rdata"}, bus_if.i_rdata, m_irdata);
        check_eq({tag, "_d_rdata"}, bus_if.d_rdata, m_drdata);
        check_eq({tag, "_err"}, bus_if.err, m_err);
    endtask

    // Entered on the first strobe cycle; returns on the completion (done) cycle with the request dropped.
    task automatic serve(input bit is_data, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input int lat, input int flush_cyc);
        bit          disc = 1'b0;
        bit          hit  = 1'b0;
        logic [31:0] rd   = '0;
        for (int c = 1; c <= TIMEOUT; c++) begin
            check_eq("strobe_rd", bus_if.mem_read, !(is_data && we));
            check_eq("strobe_wr", bus_if.mem_write, is_data && we);
            check_eq("mem_addr", bus_if.mem_addr, addr);
            if (is_data && we) check_eq("mem_wdata", bus_if.mem_wdata, wdata);
            check_eq("early_done", {bus_if.i_done, bus_if.d_done}, 2'b00);
            if (!is_data && c == flush_cyc) begin
                bus_if.i_flush = 1'b1;
                bus_if.i_req   = 1'b0;
                disc           = 1'b1;
            end
            #1;
            check_eq("stall_wait", bus_if.stall, exp_stall(1'b0, 1'b0));
            if (c == lat) begin
                rd               = $urandom;
                bus_if.mem_rdata = rd;
                bus_if.mem_ready = 1'b1;
                hit              = 1'b1;
            end
            tick();
            bus_if.mem_ready = 1'b0;
            bus_if.i_flush   = 1'b0;
            if (hit) break;
        end
        check_eq("strobe_drop", {bus_if.mem_read, bus_if.mem_write}, 2'b00);
        if (is_data) begin
            check_eq("d_done", bus_if.d_done, 1'b1);
            check_eq("d_side_i_done", bus_if.i_done, 1'b0);
            if (!hit) m_drdata = '0;
            else if (!we) m_drdata = rd;
        end else begin
            check_eq("i_done", bus_if.i_done, !disc);
            check_eq("i_side_d_done", bus_if.d_done, 1'b0);
            if (!disc) m_irdata = hit ? rd : 32'h0;
        end
        if (!hit) m_err = 1'b1;
        check_results("done");
        #1;
        check_eq("stall_done", bus_if.stall, exp_stall(is_data, !is_data && !disc));
        if (is_data) bus_if.d_req = 1'b0;
        else         bus_if.i_req = 1'b0;
        #1;
        check_eq("stall_drop", bus_if.stall, exp_stall(is_data, !is_data && !disc));
    endtask

    task automatic finish_idle();
        tick();
        check_eq("done_pulse", {bus_if.i_done, bus_if.d_done}, 2'b00);
        check_eq("idle_strobe", {bus_if.mem_read, bus_if.mem_write}, 2'b00);
    endtask

    task automatic access(input bit is_data, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int lat, input int flush_cyc);
        if (is_data) begin
            bus_if.d_req   = 1'b1;
            bus_if.d_we    = we;
            bus_if.d_addr  = addr;
            bus_if.d_wdata = wdata;
        end else begin
            bus_if.i_req  = 1'b1;
            bus_if.i_addr = addr;
        end
        #1;
        check_eq("stall_req", bus_if.stall, 1'b1);
        tick();
        serve(is_data, we, addr, wdata, lat, flush_cyc);
        finish_idle();
    endtask

    task automatic dual(input logic [31:0] daddr, input int dlat,
                        input logic [31:0] iaddr, input int ilat, input int iflush);
        bus_if.d_req   = 1'b1;
        bus_if.d_we    = 1'b0;
        bus_if.d_addr  = daddr;
        bus_if.d_wdata = $urandom;
        bus_if.i_req   = 1'b1;
        bus_if.i_addr  = iaddr;
        #1;
        check_eq("stall_dual", bus_if.stall, 1'b1);
        tick();
        serve(1'b1, 1'b0, daddr, 32'h0, dlat, 0);
        tick();
        serve(1'b0, 1'b0, iaddr, 32'h0, ilat, iflush);
        finish_idle();
    endtask

    initial begin : main
        int          kind;
        int          lat;
        int          ilat;
        int          fl;
        logic [31:0] a;
        logic [31:0] a2;
        logic [31:0] w;

        rst              = 1'b1;
        bus_if.i_req     = 1'b0;
        bus_if.i_addr    = '0;
        bus_if.i_flush   = 1'b0;
        bus_if.d_req     = 1'b0;
        bus_if.d_we      = 1'b0;
        bus_if.d_addr    = '0;
        bus_if.d_wdata   = '0;
        bus_if.mem_rdata = '0;
        bus_if.mem_ready = 1'b0;
        tick();
        tick();
        check_eq("rst_strobe", {bus_if.mem_read, bus_if.mem_write}, 2'b00);
        check_eq("rst_mem_addr", bus_if.mem_addr, 32'h0);
        check_eq("rst_mem_wdata", bus_if.mem_wdata, 32'h0);
        check_eq("rst_done", {bus_if.i_done, bus_if.d_done}, 2'b00);
        check_eq("rst_stall", bus_if.stall, 1'b0);
        check_results("rst");
        rst = 1'b0;
        tick();

        // Fetch of 0x40 answered on the third strobe cycle.
        access(1'b0, 1'b0, 32'h40, 32'h0, 3, 0);
        // Simultaneous fetch and load: load at 0x100 served first.
        dual(32'h100, 2, 32'h44, 1, 0);
        // Store keeps address/data stable until mem_ready and leaves d_rdata alone.
        access(1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 3, 0);
        // Fetch flushed in its first strobe cycle, then a fetch from the branch target.
        access(1'b0, 1'b0, 32'h48, 32'h0, 3, 1);
        access(1'b0, 1'b0, 32'h80, 32'h0, 1, 0);

        // Stray mem_ready while idle does nothing.
        bus_if.mem_rdata = 32'hA5A5_5A5A;
        bus_if.mem_ready = 1'b1;
        tick();
        bus_if.mem_ready = 1'b0;
        check_eq("spurious_strobe", {bus_if.mem_read, bus_if.mem_write}, 2'b00);
        check_eq("spurious_done", {bus_if.i_done, bus_if.d_done}, 2'b00);
        check_results("spurious");

        // Flush in idle holds off the fetch grant for that cycle.
        bus_if.i_req   = 1'b1;
        bus_if.i_addr  = 32'h90;
        bus_if.i_flush = 1'b1;
        #1;
        check_eq("stall_flush", bus_if.stall, 1'b0);
        tick();
        check_eq("flush_block", bus_if.mem_read, 1'b0);
        bus_if.i_flush = 1'b0;
        #1;
        check_eq("stall_after_flush", bus_if.stall, 1'b1);
        tick();
        serve(1'b0, 1'b0, 32'h90, 32'h0, 2, 0);
        finish_idle();

        // Load that never gets mem_ready.
        access(1'b1, 1'b0, 32'h300, 32'h0, TIMEOUT + 1, 0);
        check_eq("err_sticky_a", bus_if.err, 1'b1);
        access(1'b0, 1'b0, 32'h94, 32'h0, 2, 0);
        check_eq("err_sticky_b", bus_if.err, 1'b1);

        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 3);
            lat  = ($urandom_range(0, 7) == 0) ? TIMEOUT + 1 : $urandom_range(1, TIMEOUT);
            ilat = ($urandom_range(0, 7) == 0) ? TIMEOUT + 1 : $urandom_range(1, TIMEOUT);
            a    = $urandom & 32'hFFFF_FFFC;
            a2   = $urandom & 32'hFFFF_FFFC;
            w    = $urandom;
            fl   = 0;
            if ($urandom_range(0, 3) == 0) fl = $urandom_range(1, (ilat > TIMEOUT) ? TIMEOUT : ilat);
            case (kind)
                0:       access(1'b0, 1'b0, a, 32'h0, ilat, fl);
                1:       access(1'b1, 1'b0, a, w, lat, 0);
                2:       access(1'b1, 1'b1, a, w, $urandom_range(1, TIMEOUT), 0);
                default: dual(a, lat, a2, ilat, fl);
            endcase
        end

        // Reset in the middle of a load drops everything at once.
        bus_if.d_req  = 1'b1;
        bus_if.d_we   = 1'b0;
        bus_if.d_addr = 32'h400;
        tick();
        tick();
        check_eq("pre_rst_read", bus_if.mem_read, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        m_irdata = '0;
        m_drdata = '0;
        m_err    = 1'b0;
        check_eq("arst_strobe", {bus_if.mem_read, bus_if.mem_write}, 2'b00);
        check_eq("arst_mem_addr", bus_if.mem_addr, 32'h0);
        check_eq("arst_done", {bus_if.i_done, bus_if.d_done}, 2'b00);
        check_results("arst");
        bus_if.d_req = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        access(1'b0, 1'b0, 32'h500, 32'h0, 2, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
